// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bus between the multicycle controller and its datapath
interface multicycle_control_if;
  logic [5:0]  Opcode;
  logic        MemReady;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        IRWrite;
  logic        ALUSrcA;
  logic        RegWrite;
  logic        RegDst;
  logic [1:0]  PCSource;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUOp;
  logic [3:0]  State;
  logic        Illegal;
  logic [15:0] InstrCount;

  modport master (
    output Opcode, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, State,
           Illegal, InstrCount
  );

  modport slave (
    input  Opcode, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, State,
           Illegal, InstrCount
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM sequencing a multicycle MIPS-style datapath
// Handles LW/SW/R-type/BEQ/J/ADDI, flags unsupported opcodes and counts retired instructions.
module multicycle_control (
  input  logic                 CLK,
  input  logic                 Reset_L,
  multicycle_control_if.slave  bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTEXE   = 4'd6,
    RTWB    = 4'd7,
    BEQ     = 4'd8,
    JUMP    = 4'd9,
    ADDIEXE = 4'd10,
    ADDIWB  = 4'd11,
    ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_FUNC = 4'b1111;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_instr_count;
  logic        r_illegal;
  logic        w_retire;

  logic        w_pc_write;
  logic        w_pc_write_cond;
  logic        w_iord;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_mem_to_reg;
  logic        w_ir_write;
  logic        w_alu_src_a;
  logic        w_reg_write;
  logic        w_reg_dst;
  logic [1:0]  w_pc_source;
  logic [1:0]  w_alu_src_b;
  logic [3:0]  w_alu_op;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state       <= FETCH;
      r_instr_count <= 16'd0;
      r_illegal     <= 1'b0;
    end else begin
      r_state   <= w_next;
      // Registered alongside the state so the pulse lines up with State=ILLEGAL
      r_illegal <= (w_next == ILLEGAL);
      if (w_retire) begin
        r_instr_count <= r_instr_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    w_retire        = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_ir_write      = 1'b0;
    w_alu_src_a     = 1'b0;
    w_reg_write     = 1'b0;
    w_reg_dst       = 1'b0;
    w_pc_source     = 2'b00;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 4'b0000;

    case (r_state)
      FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_alu_op    = ALU_ADD;
        if (bus.MemReady) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = DECODE;
        end
      end
      DECODE: begin
        w_alu_src_b = 2'b11;
        w_alu_op    = ALU_ADD;
        case (bus.Opcode)
          OP_RTYPE:     w_next = RTEXE;
          OP_LW, OP_SW: w_next = MEMADR;
          OP_BEQ:       w_next = BEQ;
          OP_J:         w_next = JUMP;
          OP_ADDI:      w_next = ADDIEXE;
          default:      w_next = ILLEGAL;
        endcase
      end
      MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_op    = ALU_ADD;
        w_next      = (bus.Opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (bus.MemReady) begin
          w_next = MEMWB;
        end
      end
      MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_next       = FETCH;
        w_retire     = 1'b1;
      end
      MEMWR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (bus.MemReady) begin
          w_next   = FETCH;
          w_retire = 1'b1;
        end
      end
      RTEXE: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALU_FUNC;
        w_next      = RTWB;
      end
      RTWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
        w_next      = FETCH;
        w_retire    = 1'b1;
      end
      BEQ: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = ALU_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 2'b01;
        w_next          = FETCH;
        w_retire        = 1'b1;
      end
      JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'b10;
        w_next      = FETCH;
        w_retire    = 1'b1;
      end
      ADDIEXE: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_op    = ALU_ADD;
        w_next      = ADDIWB;
      end
      ADDIWB: begin
        w_reg_write = 1'b1;
        w_next      = FETCH;
        w_retire    = 1'b1;
      end
      ILLEGAL: begin
        w_next = FETCH;
      end
      default: begin
        w_next = FETCH;
      end
    endcase
  end

  // Write/request strobes are held off for the whole time reset is low, not just at the edge
  assign bus.PCWrite     = w_pc_write      & Reset_L;
  assign bus.PCWriteCond = w_pc_write_cond & Reset_L;
  assign bus.MemRead     = w_mem_read      & Reset_L;
  assign bus.MemWrite    = w_mem_write     & Reset_L;
  assign bus.IRWrite     = w_ir_write      & Reset_L;
  assign bus.RegWrite    = w_reg_write     & Reset_L;
  assign bus.IorD        = w_iord;
  assign bus.MemtoReg    = w_mem_to_reg;
  assign bus.ALUSrcA     = w_alu_src_a;
  assign bus.RegDst      = w_reg_dst;
  assign bus.PCSource    = w_pc_source;
  assign bus.ALUSrcB     = w_alu_src_b;
  assign bus.ALUOp       = w_alu_op;
  assign bus.State       = r_state;
  assign bus.Illegal     = r_illegal;
  assign bus.InstrCount  = r_instr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_RTEXE = 6, S_RTWB = 7, S_BEQ = 8, S_JUMP = 9,
                 S_ADDIEXE = 10, S_ADDIWB = 11, S_ILLEGAL = 12;

  typedef struct packed {
    logic [3:0]  st;
    logic        mr;
    logic [17:0] ctrl;
    logic [15:0] cnt;
    logic        il;
  } rec_t;

  logic CLK = 1'b0;
  logic Reset_L;

  multicycle_control_if bus();

  multicycle_control dut (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  rec_t        sb_q[$];
  rec_t        plan[$];
  rec_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt;
  logic [17:0] dut_ctrl;

  assign dut_ctrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                     bus.MemtoReg, bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
                     bus.PCSource, bus.ALUSrcB, bus.ALUOp};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Control word each state must present, straight from the state table
  function automatic logic [17:0] exp_ctrl(input int st, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd;
    logic [1:0] pcs, asb;
    logic [3:0] op;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd} = '0;
    pcs = 2'b00; asb = 2'b00; op = 4'b0000;
    case (st)
      S_FETCH:   begin mrd = 1; asb = 2'b01; op = 4'b0010; irw = mr; pcw = mr; end
      S_DECODE:  begin asb = 2'b11; op = 4'b0010; end
      S_MEMADR:  begin asa = 1; asb = 2'b10; op = 4'b0010; end
      S_MEMRD:   begin mrd = 1; iord = 1; end
      S_MEMWB:   begin rw = 1; m2r = 1; end
      S_MEMWR:   begin mwr = 1; iord = 1; end
      S_RTEXE:   begin asa = 1; op = 4'b1111; end
      S_RTWB:    begin rw = 1; rd = 1; end
      S_BEQ:     begin asa = 1; op = 4'b0110; pcwc = 1; pcs = 2'b01; end
      S_JUMP:    begin pcw = 1; pcs = 2'b10; end
      S_ADDIEXE: begin asa = 1; asb = 2'b10; op = 4'b0010; end
      S_ADDIWB:  begin rw = 1; end
      default:   ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, asb, op};
  endfunction

  function automatic rec_t mk(input int st, input logic mr);
    rec_t r;
    r.st   = 4'(st);
    r.mr   = mr;
    r.ctrl = exp_ctrl(st, mr);
    r.cnt  = exp_cnt;
    r.il   = (st == S_ILLEGAL);
    return r;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Per-cycle expectation for one instruction, given memory stall counts
  task automatic build(input logic [5:0] op, input int fstall, input int mstall, output bit retires);
    plan.delete();
    retires = 1'b1;
    repeat (fstall) plan.push_back(mk(S_FETCH, 1'b0));
    plan.push_back(mk(S_FETCH, 1'b1));
    plan.push_back(mk(S_DECODE, rnd_bit()));
    case (op)
      6'b100011: begin
        plan.push_back(mk(S_MEMADR, rnd_bit()));
        repeat (mstall) plan.push_back(mk(S_MEMRD, 1'b0));
        plan.push_back(mk(S_MEMRD, 1'b1));
        plan.push_back(mk(S_MEMWB, rnd_bit()));
      end
      6'b101011: begin
        plan.push_back(mk(S_MEMADR, rnd_bit()));
        repeat (mstall) plan.push_back(mk(S_MEMWR, 1'b0));
        plan.push_back(mk(S_MEMWR, 1'b1));
      end
      6'b000000: begin
        plan.push_back(mk(S_RTEXE, rnd_bit()));
        plan.push_back(mk(S_RTWB, rnd_bit()));
      end
      6'b000100: plan.push_back(mk(S_BEQ, rnd_bit()));
      6'b000010: plan.push_back(mk(S_JUMP, rnd_bit()));
      6'b001000: begin
        plan.push_back(mk(S_ADDIEXE, rnd_bit()));
        plan.push_back(mk(S_ADDIWB, rnd_bit()));
      end
      default: begin
        plan.push_back(mk(S_ILLEGAL, rnd_bit()));
        retires = 1'b0;
      end
    endcase
  endtask

  // Called at posedge+1 with the DUT in FETCH; leaves at posedge+1 after ncyc cycles
  task automatic run_plan(input logic [5:0] op, input int ncyc);
    bus.Opcode = op;
    for (int i = 0; i < ncyc; i++) sb_q.push_back(plan[i]);
    for (int i = 0; i < ncyc; i++) begin
      bus.MemReady = plan[i].mr;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_instr(input logic [5:0] op, input int fstall, input int mstall);
    bit ret;
    build(op, fstall, mstall, ret);
    run_plan(op, plan.size());
    if (ret) exp_cnt = exp_cnt + 16'd1;
  endtask

  always @(negedge CLK) begin
    if (Reset_L && sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("state", {28'd0, bus.State}, {28'd0, mon_e.st});
      check("ctrl", {14'd0, dut_ctrl}, {14'd0, mon_e.ctrl});
      check("count", {16'd0, bus.InstrCount}, {16'd0, mon_e.cnt});
      check("illegal", {31'd0, bus.Illegal}, {31'd0, mon_e.il});
    end
  end

  initial begin
    bit          ret;
    logic [5:0]  op;
    int          fs, ms;

    bus.Opcode   = 6'd0;
    bus.MemReady = 1'b0;
    exp_cnt      = 16'd0;
    Reset_L      = 1'b1;
    #1 Reset_L   = 1'b0;
    #1;
    check("rst_state", {28'd0, bus.State}, S_FETCH);
    check("rst_count", {16'd0, bus.InstrCount}, 32'd0);
    check("rst_illegal", {31'd0, bus.Illegal}, 32'd0);
    bus.MemReady = 1'b1;
    #1;
    check("rst_enables", {26'd0, bus.PCWrite, bus.PCWriteCond, bus.MemRead,
                          bus.MemWrite, bus.IRWrite, bus.RegWrite}, 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1 Reset_L = 1'b1;

    do_instr(6'b100011, 0, 0);
    check("lw_count", {16'd0, bus.InstrCount}, {16'd0, exp_cnt});
    do_instr(6'b000000, 0, 0);
    do_instr(6'b000100, 0, 0);
    do_instr(6'b101011, 0, 3);
    do_instr(6'b111111, 0, 0);
    check("illegal_count", {16'd0, bus.InstrCount}, {16'd0, exp_cnt});
    do_instr(6'b001000, 2, 0);
    do_instr(6'b000010, 1, 0);
    do_instr(6'b100011, 1, 2);

    repeat (300) begin
      case ($urandom_range(0, 7))
        0:       op = 6'b100011;
        1:       op = 6'b101011;
        2:       op = 6'b000000;
        3:       op = 6'b000100;
        4:       op = 6'b000010;
        5:       op = 6'b001000;
        default: op = 6'($urandom);
      endcase
      fs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      ms = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      do_instr(op, fs, ms);
    end

    // Abandon a load while it waits in MEMRD
    build(6'b100011, 0, 2, ret);
    run_plan(6'b100011, 3);
    check("pre_rst_state", {28'd0, bus.State}, S_MEMRD);
    bus.MemReady = 1'b0;
    #2 Reset_L = 1'b0;
    #1;
    exp_cnt = 16'd0;
    check("mid_rst_state", {28'd0, bus.State}, S_FETCH);
    check("mid_rst_count", {16'd0, bus.InstrCount}, {16'd0, exp_cnt});
    check("mid_rst_enables", {26'd0, bus.PCWrite, bus.PCWriteCond, bus.MemRead,
                              bus.MemWrite, bus.IRWrite, bus.RegWrite}, 32'd0);
    bus.MemReady = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_hold_state", {28'd0, bus.State}, S_FETCH);
    check("rst_hold_enables", {26'd0, bus.PCWrite, bus.PCWriteCond, bus.MemRead,
                               bus.MemWrite, bus.IRWrite, bus.RegWrite}, 32'd0);
    Reset_L = 1'b1;

    repeat (65535) do_instr(6'b000010, 0, 0);
    check("count_ffff", {16'd0, bus.InstrCount}, {16'd0, exp_cnt});
    do_instr(6'b000010, 0, 0);
    check("count_wrap", {16'd0, bus.InstrCount}, {16'd0, exp_cnt});
    do_instr(6'b100011, 0, 0);

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The interface SHALL have one clock and an asynchronous, active-low reset: CLK is the single clock; Reset_L is asynchronous and active-low.
REQ-002 Ports SHALL be:
- CLK  in  1  rising-edge clock.
- Reset_L  in  1  asynchronous active-low reset.
- Opcode  in  6  instruction bits [31:26] from the IR, stable from DECODE onward.
- MemReady  in  1  memory access completes this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath enables and selects.
- PCSource  out  2  PC mux select: 00 ALU, 01 ALUOut, 10 jump target.
- ALUSrcB  out  2  ALU B select: 00 reg B, 01 const 4, 10 sign-extended immediate, 11 shifted immediate.
- ALUOp  out  4  to ALUControl: 0010 add, 0110 sub, 1111 decode FuncCode.
- State  out  4  current state, for debug.
- Illegal  out  1  one-cycle pulse on an unsupported opcode.
- InstrCount  out  16  count of retired instructions.

Function
REQ-003 The block SHALL be a Moore FSM; all outputs except Illegal SHALL decode from the registered state.
REQ-004 States and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, RTWB=7, BEQ=8, JUMP=9, ADDIEXE=10, ADDIWB=11, ILLEGAL=12.
REQ-005 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0010, PCSource=00.
REQ-006 FETCH SHALL assert IRWrite=1 and PCWrite=1 only in a cycle where MemReady=1.
REQ-007 FETCH SHALL hold while MemReady=0 and SHALL go to DECODE when MemReady=1.
REQ-008 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=0010.
REQ-009 DECODE SHALL branch on Opcode:
- 000000 -> RTEXE.
- 100011 or 101011 -> MEMADR.
- 000100 -> BEQ.
- 000010 -> JUMP.
- 001000 -> ADDIEXE.
- any other value -> ILLEGAL.
REQ-010 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=0010, then go to MEMRD if Opcode=100011, else to MEMWR.
REQ-011 MEMRD SHALL drive MemRead=1, IorD=1, hold while MemReady=0, and go to MEMWB when MemReady=1.
REQ-012 MEMWR SHALL drive MemWrite=1, IorD=1 while waiting; it SHALL go to FETCH on MemReady=1, deasserting MemWrite the cycle after.
REQ-013 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-014 RTEXE SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=1111, then go to RTWB.
REQ-015 RTWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-016 BEQ SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=0110, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-017 JUMP SHALL drive PCWrite=1, PCSource=10, then go to FETCH.
REQ-018 ADDIEXE SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=0010, then go to ADDIWB.
REQ-019 ADDIWB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0, then go to FETCH.
REQ-020 ILLEGAL SHALL assert Illegal=1 for exactly one cycle, drive no write enables, and go to FETCH.
REQ-021 Any 1-bit output not listed for a state SHALL be 0; unlisted ALUOp, ALUSrcB and PCSource SHALL be 0000, 00 and 00.
REQ-022 InstrCount SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, RTWB, BEQ, JUMP or ADDIWB.
REQ-023 InstrCount SHALL NOT increment on a transition from ILLEGAL, and SHALL wrap from 0xFFFF to 0x0000.
REQ-024 Instruction latency SHALL be 5 cycles for LW, 4 for SW/R-type/ADDI, and 3 for BEQ/JUMP, with MemReady=1 on first request; each MemReady=0 cycle SHALL add one cycle.
REQ-025 Unused state encodings 13-15 SHALL go to FETCH on the next clock.

Reset
REQ-026 Reset_L=0 SHALL immediately force State=FETCH, InstrCount=0 and Illegal=0, without waiting for a clock.
REQ-027 While Reset_L=0, PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite and RegWrite SHALL be forced to 0.
REQ-028 Reset asserted mid-instruction SHALL abandon the instruction with no count increment; after release, the first rising edge SHALL evaluate FETCH.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset, MemReady=1, Opcode=100011 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; InstrCount=1.
- Opcode=000000 -> state 6 shows ALUOp=1111; state 7 shows RegDst=1, RegWrite=1; 4 cycles.
- Opcode=000100 -> state 8 shows ALUOp=0110, PCWriteCond=1, PCSource=01; 3 cycles.
- Opcode=101011 with MemReady=0 for 3 cycles in MEMWR -> MemWrite held 4 cycles; one increment.
- Opcode=111111 -> State=12, Illegal pulses once, InstrCount unchanged, returns to FETCH.
- InstrCount preloaded near 0xFFFF via 65535 JUMPs -> wraps to 0x0000; Reset_L low in MEMRD -> State=0 and all enables 0 asynchronously.
